rca_slice_sequencer: RTL
========================

// Module: rca_slice_sequencer
// PURPOSE
//  Multi-cycle adder controller: adds two WIDTH-bit operands by time-multiplexing ONE
//  rca_4_full_addr instance, one 4-bit slice per clock, LSB slice first, carry held in a
//  register between slices. Sits between a requester and the adder datapath.
//  Valid/ready handshake on input and output. One operation in flight at a time.
// PARAMETERS
//  WIDTH   16   operand/sum width; must be a multiple of 4 and >= 4
//  SLICES  WIDTH/4 (localparam, derived, not overridable) slice count
// PORTS
//  i_clk    in   1      clock, rising edge
//  i_rst    in   1      asynchronous reset, active-high
//  i_valid  in   1      request valid; operands sampled when i_valid && o_ready
//  o_ready  out  1      block can accept a request (high only in IDLE)
//  i_a      in   WIDTH  operand A
//  i_b      in   WIDTH  operand B
//  i_cin    in   1      carry-in to slice 0
//  o_valid  out  1      result valid (high only in DONE)
//  i_ready  in   1      consumer accepts result when o_valid && i_ready
//  o_sum    out  WIDTH  (i_a + i_b + i_cin) mod 2^WIDTH
//  o_cout   out  1      carry out of MSB slice
//  o_ovf    out  1      signed overflow; present only with RCA_SEQ_OVF_EN
// BEHAVIOUR
//  Reset (async, i_rst=1): state=IDLE, o_ready=1, o_valid=0, o_sum=0, o_cout=0,
//   operand/carry/counter regs=0 (o_ovf=0). Effective immediately, no clock needed.
//  Registers: a_sh, b_sh (WIDTH, shift right 4/slice), sum_sh (WIDTH), cy (1), cnt (ceil log2 SLICES, min 1).
//  FSM:
//   IDLE: o_ready=1. On i_valid: a_sh<=i_a, b_sh<=i_b, cy<=i_cin, cnt<=0, -> RUN.
//   RUN : slice adder inputs = a_sh[3:0], b_sh[3:0], cy. Each edge:
//         sum_sh<={slice_sum, sum_sh[WIDTH-1:4]}; cy<=slice_cout; a_sh,b_sh >>=4; cnt++.
//         When cnt==SLICES-1 on that edge -> DONE; o_sum<=final sum_sh value, o_cout<=slice_cout.
//   DONE: o_valid=1; o_sum/o_cout held stable. On i_ready -> IDLE (o_valid drops next cycle).
//  Latency: o_valid rises exactly SLICES edges after the accept edge (16-bit: 4).
//  Throughput: at best one op per SLICES+2 cycles (accept, SLICES run, 1 DONE).
//  o_ready/o_valid are decoded from registered state only; no comb path from i_valid/i_ready.
//  i_valid while RUN/DONE: ignored, operands not sampled, no queuing.
//  i_ready while IDLE/RUN: ignored. i_ready held low in DONE: hold indefinitely.
//  Wrap-around: sum is modulo 2^WIDTH; carry out of the MSB goes to o_cout only.
//  WIDTH=4: SLICES=1, single RUN cycle, same FSM.
//  o_sum/o_cout keep the last result after DONE->IDLE until the next DONE update.
//  Reset mid-RUN or mid-DONE: aborts the operation, no o_valid pulse, all regs as reset.
//  Operand inputs may change freely after the accept edge.
// CONFIGURATION
//  RCA_SEQ_OVF_EN defined: port o_ovf exists. On the final RUN edge
//   o_ovf <= (a_msb == b_msb) && (sum_msb != a_msb), with a_msb/b_msb = bit 3 of the last
//   slice operands and sum_msb = bit 3 of the last slice sum. Held in DONE like o_sum.
//  Not defined: o_ovf port and its logic absent; all other behaviour identical.
// TESTING (WIDTH=16)
//  1 Assert i_rst 3 cycles, release -> o_ready=1, o_valid=0, o_sum=0x0000, o_cout=0.
//  2 A=0x1234 B=0x4321 cin=0 -> o_sum=0x5555 o_cout=0, o_valid 4 edges after accept.
//  3 A=0xFFFF B=0x0001 cin=0 -> o_sum=0x0000 o_cout=1 (carry crosses all slices), ovf=0.
//  4 A=0x7FFF B=0x0001 cin=0 -> o_sum=0x8000 o_cout=0; with RCA_SEQ_OVF_EN o_ovf=1.
//  5 i_ready=0 for 10 cycles in DONE; toggle i_valid with new operands in RUN/DONE ->
//    o_valid and o_sum held, new operands not taken, o_ready=0 throughout.
//  6 i_rst pulse during 2nd RUN cycle -> IDLE, no o_valid; then A=0x00FF B=0x0F0F cin=1
//    -> o_sum=0x100F o_cout=0.

Source files
------------

// File: rtl/rca_slice_sequencer_if.sv
// Request/result bundle for rca_slice_sequencer. o_ovf exists only when
// RCA_SEQ_OVF_EN is defined.
interface rca_slice_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
`ifdef RCA_SEQ_OVF_EN
  logic             o_ovf;
`endif

  modport master (
    output i_valid, i_a, i_b, i_cin, i_ready,
`ifdef RCA_SEQ_OVF_EN
    input  o_ovf,
`endif
    input  o_ready, o_valid, o_sum, o_cout
  );

  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_ready,
`ifdef RCA_SEQ_OVF_EN
    output o_ovf,
`endif
    output o_ready, o_valid, o_sum, o_cout
  );
endinterface

// File: rtl/rca_slice_sequencer.sv
// Multi-cycle adder: one 4-bit ripple slice reused per clock, LSB first.
// Optional signed-overflow output enabled by defining RCA_SEQ_OVF_EN.
module rca_4_full_addr (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
endmodule

module rca_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input logic                  i_clk,
  input logic                  i_rst,
  rca_slice_sequencer_if.slave bus
);
  localparam int SLICES = WIDTH / 4;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               cy_q, cy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [3:0]         slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   sum_sh_next;
`ifdef RCA_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  rca_4_full_addr u_slice (
    .a_i    (a_q[3:0]),
    .b_i    (b_q[3:0]),
    .cin_i  (cy_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Shift-then-overwrite keeps the WIDTH=4 case free of reversed slices.
  always_comb begin
    sum_sh_next = sum_sh_q >> 4;
    sum_sh_next[WIDTH-1 -: 4] = slice_sum;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_sh_d = sum_sh_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef RCA_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_a;
          b_d     = bus.i_b;
          cy_d    = bus.i_cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_sh_d = sum_sh_next;
        cy_d     = slice_cout;
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SLICES - 1)) begin
          state_d = S_DONE;
          sum_d   = sum_sh_next;
          cout_d  = slice_cout;
`ifdef RCA_SEQ_OVF_EN
          ovf_d   = (a_q[3] == b_q[3]) && (slice_sum[3] != a_q[3]);
`endif
        end
      end
      S_DONE: begin
        if (bus.i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_sh_q <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_sh_q <= sum_sh_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef RCA_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.o_ready = (state_q == S_IDLE);
  assign bus.o_valid = (state_q == S_DONE);
  assign bus.o_sum   = sum_q;
  assign bus.o_cout  = cout_q;
`ifdef RCA_SEQ_OVF_EN
  assign bus.o_ovf   = ovf_q;
`endif
endmodule
